// File: rtl/adder_ctrl_rb.sv
// adder_ctrl_rb: register bank + start/done sequencer for the adder accelerator.
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async low reset; i_en_amba_write,
// i_addr_wc, i_data_wc, i_strb write side; i_addr_rc/o_data_rc comb read side;
// o_is_busy; o_add_start, o_add_a, o_add_b, i_add_done, i_add_sum adder side;
// o_irq only when ADDER_CTRL_IRQ_EN is defined (also enables CTRL.IRQ_EN).
module adder_ctrl_rb #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_en_amba_write,
  input  logic [31:0] i_addr_wc,
  input  logic [31:0] i_data_wc,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_addr_rc,
  output logic [31:0] o_data_rc,
  output logic        o_is_busy,
  output logic        o_add_start,
  output logic [31:0] o_add_a,
  output logic [31:0] o_add_b,
  input  logic        i_add_done,
  input  logic [32:0] i_add_sum
`ifdef ADDER_CTRL_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    STORE
  } state_t;

  state_t               state;
  logic [TW-1:0]        tmr;
  logic [32:0]          sum_q;
  logic [31:0]          op_a;
  logic [31:0]          op_b;
  logic [31:0]          result;
  logic                 carry;
  logic                 done;
  logic                 tmo;
  logic [CNT_WIDTH-1:0] op_cnt;
  logic                 irq_en;

  logic                 w_ok;
  logic                 r_ok;
  logic                 wr_ctrl;
  logic                 wr_opa;
  logic                 wr_opb;
  logic                 wr_stat;
  logic [31:0]          status;

  // Busy is a registered mirror of state != IDLE, so gating with it
  // drops every write while an operation is in flight.
  assign w_ok = i_en_amba_write && !o_is_busy
             && (i_addr_wc[31:8] == 24'd0)
             && (i_addr_wc[7:0] < 8'h14);
  assign r_ok = (i_addr_rc[31:8] == 24'd0)
             && (i_addr_rc[7:0] < 8'h14);

  assign wr_ctrl = w_ok && (i_addr_wc[4:2] == 3'd0) && i_strb[0];
  assign wr_opa  = w_ok && (i_addr_wc[4:2] == 3'd1);
  assign wr_opb  = w_ok && (i_addr_wc[4:2] == 3'd2);
  assign wr_stat = w_ok && (i_addr_wc[4:2] == 3'd4) && i_strb[0];

  assign o_add_a = op_a;
  assign o_add_b = op_b;

`ifdef ADDER_CTRL_IRQ_EN
  assign o_irq = irq_en & (done | tmo);
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    status = '0;
    status[0] = done;
    status[1] = carry;
    status[2] = tmo;
    status[3] = o_is_busy;
    status[8 +: CNT_WIDTH] = op_cnt;
  end

  always_comb begin
    o_data_rc = '0;
    if (r_ok) begin
      unique case (i_addr_rc[4:2])
        3'd0:    o_data_rc = {30'd0, irq_en, 1'b0};
        3'd1:    o_data_rc = op_a;
        3'd2:    o_data_rc = op_b;
        3'd3:    o_data_rc = result;
        3'd4:    o_data_rc = status;
        default: o_data_rc = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state       <= IDLE;
      tmr         <= '0;
      sum_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      carry       <= 1'b0;
      done        <= 1'b0;
      tmo         <= 1'b0;
      op_cnt      <= '0;
      o_add_start <= 1'b0;
      o_is_busy   <= 1'b0;
`ifdef ADDER_CTRL_IRQ_EN
      irq_en      <= 1'b0;
`endif
    end else begin
      o_add_start <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (wr_opa && i_strb[i])
          op_a[8*i +: 8] <= i_data_wc[8*i +: 8];
        if (wr_opb && i_strb[i])
          op_b[8*i +: 8] <= i_data_wc[8*i +: 8];
      end
      if (wr_stat) begin
        if (i_data_wc[0]) done <= 1'b0;
        if (i_data_wc[2]) tmo  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (wr_ctrl) begin
`ifdef ADDER_CTRL_IRQ_EN
            irq_en <= i_data_wc[1];
`endif
            // CLR first; a simultaneous START then launches on cleared state.
            if (i_data_wc[2]) begin
              result <= '0;
              carry  <= 1'b0;
              done   <= 1'b0;
              tmo    <= 1'b0;
              op_cnt <= '0;
            end
            if (i_data_wc[0]) begin
              done        <= 1'b0;
              tmo         <= 1'b0;
              state       <= LAUNCH;
              o_is_busy   <= 1'b1;
              o_add_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done has priority over an expiring timer.
          if (i_add_done) begin
            sum_q <= i_add_sum;
            state <= STORE;
          end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo       <= 1'b1;
            state     <= IDLE;
            o_is_busy <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STORE: begin
          result    <= sum_q[31:0];
          carry     <= sum_q[32];
          done      <= 1'b1;
          op_cnt    <= op_cnt + 1'b1;
          state     <= IDLE;
          o_is_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_ctrl_rb.sv
// tb_adder_ctrl_rb: scoreboard bench for adder_ctrl_rb.
// Stimulus pushes expected outcomes; monitor pops and compares.
`timescale 1ns/1ps
module tb_adder_ctrl_rb;
  localparam int T  = 64;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] raddr = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        start;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_done = 1'b0;
  logic [32:0] add_sum = '0;
`ifdef ADDER_CTRL_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  adder_ctrl_rb #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .i_en_amba_write(en),
    .i_addr_wc(waddr),
    .i_data_wc(wdata),
    .i_strb(wstrb),
    .i_addr_rc(raddr),
    .o_data_rc(rdata),
    .o_is_busy(busy),
    .o_add_start(start),
    .o_add_a(add_a),
    .o_add_b(add_b),
    .i_add_done(add_done),
    .i_add_sum(add_sum)
`ifdef ADDER_CTRL_IRQ_EN
    ,
    .o_irq(irq)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [31:0]   m_a, m_b, m_res;
  logic          m_carry, m_done, m_to, m_irqen;
  logic [CW-1:0] m_cnt;

  typedef struct {
    int          blen;
    logic [31:0] res;
    logic [31:0] st;
    logic        irq;
  } comp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_t;
  comp_t cq[$];
  rd_t   rq[$];

  int          k_cur = 0;
  logic [32:0] sum_cur = '0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic        aborting = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'd0, m_cnt, 4'd0, 1'b0, m_to, m_carry, m_done};
  endfunction

  function automatic logic m_irq();
`ifdef ADDER_CTRL_IRQ_EN
    return m_irqen & (m_done | m_to);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_a = '0; m_b = '0; m_res = '0;
    m_carry = 0; m_done = 0; m_to = 0; m_irqen = 0; m_cnt = '0;
  endtask

  // Register-map semantics, applied only while the DUT is idle.
  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    if (a[31:8] != 0 || a[7:0] >= 8'h14) return;
    case (a[7:2])
      6'd0: if (s[0]) begin
`ifdef ADDER_CTRL_IRQ_EN
        m_irqen = d[1];
`endif
        if (d[2]) begin
          m_res = 0; m_carry = 0; m_done = 0; m_to = 0; m_cnt = 0;
        end
        if (d[0]) begin m_done = 0; m_to = 0; end
      end
      6'd1: for (int i = 0; i < 4; i++)
        if (s[i]) m_a[8*i +: 8] = d[8*i +: 8];
      6'd2: for (int i = 0; i < 4; i++)
        if (s[i]) m_b[8*i +: 8] = d[8*i +: 8];
      6'd4: if (s[0]) begin
        if (d[0]) m_done = 0;
        if (d[2]) m_to = 0;
      end
      default: ;
    endcase
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    en = 1; waddr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    en = 0;
  endtask

  task automatic mw(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    m_write(a, d, s);
    wr(a, d, s);
  endtask

  task automatic drain();
    int n = 0;
    while (rq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL drain timeout");
    end
    #2;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    rd_t r;
    r.addr = a; r.exp = e;
    rq.push_back(r);
    drain();
  endtask

  // k: adder done k cycles after the start pulse; 0 means never.
  task automatic start_op(input logic [31:0] cd, input int k);
    comp_t       c;
    logic [32:0] s;
    m_write(32'h0, cd, 4'h1);
    s = {1'b0, m_a} + {1'b0, m_b};
    exp_a = m_a; exp_b = m_b; sum_cur = s; k_cur = k;
    if (k >= 1 && k <= T) begin
      m_res = s[31:0]; m_carry = s[32]; m_done = 1; m_cnt = m_cnt + 1'b1;
      c.blen = k + 2;
    end else begin
      m_to = 1;
      c.blen = T + 1;
    end
    c.res = m_res; c.st = m_status(); c.irq = m_irq();
    cq.push_back(c);
    wr(32'h0, cd, 4'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || cq.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL wait_idle timeout");
    end
    #2;
  endtask

  task automatic wait_fall();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL wait_fall timeout");
    end
  endtask

  // Adder stand-in: checks operands at launch, answers after k_cur cycles.
  initial begin : stub
    forever begin
      @(negedge clk);
      if (start) begin
        chk("add_a", add_a, exp_a);
        chk("add_b", add_b, exp_b);
        if (k_cur > 0) begin
          repeat (k_cur) @(posedge clk);
          #1; add_done = 1; add_sum = sum_cur;
          @(posedge clk);
          #1; add_done = 0; add_sum = {1'b1, $urandom};
        end
      end
    end
  end

  initial begin : mon
    int    bcnt;
    logic  pbusy;
    logic  pstart;
    comp_t c;
    rd_t   r;
    bcnt = 0; pbusy = 0; pstart = 0;
    forever begin
      @(negedge clk);
      if (pstart) chk("start_pulse", start, 1'b0);
      pstart = start;
      if (busy) begin
        bcnt++;
      end else if (pbusy) begin
        if (!aborting) begin
          if (cq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_completion");
          end else begin
            c = cq.pop_front();
            chk("busy_len", bcnt, c.blen);
            raddr = 32'h0C; #1;
            chk("result", rdata, c.res);
            raddr = 32'h10; #1;
            chk("status", rdata, c.st);
`ifdef ADDER_CTRL_IRQ_EN
            chk("irq", irq, c.irq);
`endif
          end
        end
        bcnt = 0;
      end else if (rq.size() != 0) begin
        r = rq.pop_front();
        raddr = r.addr; #1;
        chk($sformatf("read_%0h", r.addr), rdata, r.exp);
      end
      pbusy = busy;
    end
  end

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] cd;
    int          k;
    bit          bb;
    m_reset();
    add_sum = {1'b1, $urandom};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);
    for (int i = 0; i < 5; i++) rd(32'(i * 4), 32'h0);

    @(posedge clk); #1;
    mw(32'h4, 32'h5, 4'hF);
    mw(32'h8, 32'h7, 4'hF);
    start_op(32'h1, 4);
    wait_idle();
    rd(32'h0C, 32'h0000_000C);
    rd(32'h10, 32'h0000_0101);

    mw(32'h4, 32'hFFFF_FFFF, 4'hF);
    mw(32'h8, 32'h1, 4'hF);
    start_op(32'h1, 1);
    wait_idle();
    mw(32'h10, 32'h1, 4'h1);
    rd(32'h10, m_status());
    rd(32'h0C, m_res);

    start_op(32'h1, 0);
    wait_idle();
    rd(32'h0C, m_res);

    start_op(32'h1, T);
    wait_idle();
    start_op(32'h1, T + 1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    rd(32'h0C, m_res);
    rd(32'h10, m_status());

    rd(32'h14, 32'h0);
    rd(32'h104, 32'h0);
    mw(32'h0C, 32'hDEAD_BEEF, 4'hF);
    mw(32'h104, 32'hAAAA_AAAA, 4'hF);
    mw(32'h14, 32'h5555_5555, 4'hF);
    mw(32'h0, 32'h1, 4'hE);
    rd(32'h0C, m_res);
    rd(32'h04, m_a);
    rd(32'h10, m_status());

    mw(32'h0, 32'h2, 4'h1);
    rd(32'h0, m_irqen ? 32'h2 : 32'h0);
    start_op(32'h3, 2);
    wait_idle();
    mw(32'h10, 32'h5, 4'h1);
`ifdef ADDER_CTRL_IRQ_EN
    chk("irq_clr", irq, 1'b0);
`endif
    mw(32'h0, 32'h4, 4'h1);
    rd(32'h10, m_status());
    rd(32'h0C, m_res);
    start_op(32'h5, 3);
    wait_idle();

    start_op(32'h1, 0);
    repeat (5) @(negedge clk);
    cq.delete(cq.size() - 1);
    aborting = 1;
    #2 rst_n = 0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_start", start, 1'b0);
    chk("abort_data", rdata, 32'h0);
    m_reset();
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(negedge clk);
    aborting = 0;
    for (int i = 0; i < 5; i++) rd(32'(i * 4), 32'h0);

    mw(32'h4, 32'h1234_5678, 4'b0010);
    rd(32'h4, 32'h0000_5600);
    mw(32'h8, 32'h11, 4'hF);
    start_op(32'h1, 5);
    wr(32'h8, 32'hBEEF, 4'hF);
    wait_idle();
    rd(32'h8, m_b);

    bb = 0;
    for (int i = 0; i < 30; i++) begin
      if (!bb) begin
        mw(32'h4, $urandom, 4'($urandom_range(0, 15)));
        mw(32'h8, $urandom, 4'hF);
      end
      k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      cd = {29'd0, ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'b1};
      start_op(cd, k);
      bb = ($urandom_range(0, 2) == 0);
      if (bb) begin
        wait_fall();
      end else begin
        wait_idle();
        rd(32'h0, m_irqen ? 32'h2 : 32'h0);
        rd(32'h4, m_a);
        rd(32'h8, m_b);
      end
    end
    wait_idle();
    rd(32'h10, m_status());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
